// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: op codes, FSM states,
// default widths matching the data memory.
package mem_access_unit_pkg;

  localparam int unsigned MAU_ADDR_W = 7;
  localparam int unsigned MAU_DATA_W = 16;
  localparam int unsigned MAU_CNT_W  = 16;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_SWAP  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // True for ops that write the memory (STORE and SWAP)
  function automatic logic op_writes(op_e op);
    return (op == OP_STORE) || (op == OP_SWAP);
  endfunction

endpackage

// File: rtl/mem_access_unit_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: hold at all-ones instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_access_unit.sv
// Initiator for the pipeline data memory: accepts LOAD/STORE/SWAP requests,
// drives the memory port from registers, and returns read data on a
// valid/ready response channel. One access in flight at a time.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = MAU_ADDR_W,
  parameter int unsigned DATA_W = MAU_DATA_W,
  parameter int unsigned CNT_W  = MAU_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              op_err,
  output logic [CNT_W-1:0]  ld_cnt,
  output logic [CNT_W-1:0]  st_cnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            state_d, state_q;
  op_e               op_d, op_q;
  logic              req_ready_d, req_ready_q;
  logic              resp_valid_d, resp_valid_q;
  logic [DATA_W-1:0] resp_data_d, resp_data_q;
  logic              op_err_d, op_err_q;
  logic              mem_we_d, mem_we_q;
  logic [ADDR_W-1:0] mem_w_addr_d, mem_w_addr_q;
  logic [ADDR_W-1:0] mem_r_addr_d, mem_r_addr_q;
  logic [DATA_W-1:0] mem_data_in_d, mem_data_in_q;
  logic              ld_inc, st_inc;
  logic              accept;
  op_e               req_op_e;

  assign req_op_e = op_e'(req_op);
  assign accept   = req_valid && req_ready_q;

  // Next-state and registered-output computation for the access FSM.
  // Memory port registers are loaded on accept so address/we are already
  // on the bus during ISSUE; req_ready and resp_valid each lag their state
  // by one cycle, which gives the STORE N+2 / LOAD N+3 timing.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    req_ready_d   = 1'b0;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    op_err_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_w_addr_d  = mem_w_addr_q;
    mem_r_addr_d  = mem_r_addr_q;
    mem_data_in_d = mem_data_in_q;
    ld_inc        = 1'b0;
    st_inc        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          if (req_op_e == OP_RSVD) begin
            op_err_d = 1'b1;
          end else begin
            state_d       = ST_ISSUE;
            op_d          = req_op_e;
            req_ready_d   = 1'b0;
            mem_we_d      = op_writes(req_op_e);
            mem_w_addr_d  = req_addr;
            mem_r_addr_d  = req_addr;
            mem_data_in_d = req_wdata;
          end
        end
      end
      ST_ISSUE: begin
        st_inc  = op_writes(op_q);
        state_d = (op_q == OP_STORE) ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        resp_data_d = mem_data_out;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          ld_inc       = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_LOAD;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      op_err_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_w_addr_q  <= '0;
      mem_r_addr_q  <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      op_err_q      <= op_err_d;
      mem_we_q      <= mem_we_d;
      mem_w_addr_q  <= mem_w_addr_d;
      mem_r_addr_q  <= mem_r_addr_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_ld_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ld_inc),
    .cnt (ld_cnt)
  );

  sat_counter #(.W(CNT_W)) u_st_cnt (
    .clk (clk),
    .rst (rst),
    .inc (st_inc),
    .cnt (st_cnt)
  );

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign op_err      = op_err_q;
  assign mem_we      = mem_we_q;
  assign mem_w_addr  = mem_w_addr_q;
  assign mem_r_addr  = mem_r_addr_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a behavioural data memory (1-cycle
// registered read, read-before-write, fresh contents 16'h00FF).
module tb_mem_access_unit;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_data;
  logic          op_err;
  logic [CW-1:0] ld_cnt, st_cnt;
  logic          mem_we;
  logic [AW-1:0] mem_w_addr, mem_r_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  // second instance with 2-bit counters, memory read data tied off
  logic          r2_valid = 1'b0;
  logic          r2_ready;
  logic [1:0]    r2_op = 2'b01;
  logic [AW-1:0] r2_addr = '0;
  logic [DW-1:0] r2_wdata = '0;
  logic          r2_resp_valid;
  logic          r2_resp_ready = 1'b1;
  logic [DW-1:0] r2_resp_data;
  logic          r2_op_err;
  logic [1:0]    r2_ld_cnt, r2_st_cnt;
  logic          r2_mem_we;
  logic [AW-1:0] r2_w_addr, r2_r_addr;
  logic [DW-1:0] r2_data_in;
  logic [DW-1:0] r2_data_out = '0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int we_cycles = 0;
  logic prev_we = 1'b0;

  logic [DW-1:0] mem_arr [0:(1<<AW)-1];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .op_err(op_err), .ld_cnt(ld_cnt), .st_cnt(st_cnt), .mem_we(mem_we),
    .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_op(r2_op), .req_addr(r2_addr), .req_wdata(r2_wdata),
    .resp_valid(r2_resp_valid), .resp_ready(r2_resp_ready), .resp_data(r2_resp_data),
    .op_err(r2_op_err), .ld_cnt(r2_ld_cnt), .st_cnt(r2_st_cnt), .mem_we(r2_mem_we),
    .mem_w_addr(r2_w_addr), .mem_r_addr(r2_r_addr),
    .mem_data_in(r2_data_in), .mem_data_out(r2_data_out)
  );

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem_arr[i] = 16'h00FF;
  end

  always @(posedge clk) begin
    mem_data_out <= mem_arr[mem_r_addr];
    if (mem_we) mem_arr[mem_w_addr] <= mem_data_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every valid cycle is compared with the head of the
  // expected queue; popped on handshake.
  always @(negedge clk) begin
    if (rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'(resp_data), 32'hFFFF_FFFF);
      end else begin
        chk("resp_data", 32'(resp_data), 32'(exp_q[0]));
        chk("ready_low_in_resp", 32'(req_ready), 32'd0);
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
    if (mem_we) begin
      we_cycles++;
      chk("we_single_cycle", 32'(prev_we), 32'd0);
    end
    prev_we = mem_we;
  end

  // Drive one request and return #1 after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    issue(2'b01, a, d);
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_waddr", 32'(mem_w_addr), 32'(a));
    chk("st_wdata", 32'(mem_data_in), 32'(d));
    @(posedge clk); #1;
    chk("st_we_drop", 32'(mem_we), 32'd0);
    chk("st_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("st_ready_back", 32'(req_ready), 32'd1);
  endtask

  // LOAD (op 00) or SWAP (op 10) with optional response backpressure
  task automatic do_rd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp, input int bp);
    exp_q.push_back(exp);
    resp_ready = (bp == 0);
    issue(op, a, d);
    chk("rd_we", 32'(mem_we), (op == 2'b10) ? 32'd1 : 32'd0);
    chk("rd_raddr", 32'(mem_r_addr), 32'(a));
    @(posedge clk); #1 chk("lat_n1", 32'(resp_valid), 32'd0);
    @(posedge clk); #1 chk("lat_n2", 32'(resp_valid), 32'd0);
    @(posedge clk); #1 chk("lat_n3", 32'(resp_valid), 32'd1);
    chk("lat_data", 32'(resp_data), 32'(exp));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1 chk("hs_valid_drop", 32'(resp_valid), 32'd0);
    @(posedge clk); #1 chk("idle_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 chk("ready_after_rst", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with a request pending
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_op_err", 32'(op_err), 32'd0);
    chk("rst_ld", 32'(ld_cnt), 32'd0);
    chk("rst_st", 32'(st_cnt), 32'd0);
    chk("rst_waddr", 32'(mem_w_addr), 32'd0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 chk("ready_first_cycle", 32'(req_ready), 32'd1);

    // 2: store then load same address
    do_store(7'h05, 16'hA5A5);
    do_rd(2'b00, 7'h05, 16'h0000, 16'hA5A5, 0);
    chk("t2_st", 32'(st_cnt), 32'd1);
    chk("t2_ld", 32'(ld_cnt), 32'd1);
    chk("t2_we_cycles", 32'(we_cycles), 32'd1);

    // 3: swap on fresh location returns old contents, then load new
    do_reset();
    do_rd(2'b10, 7'h10, 16'h1234, 16'h00FF, 0);
    do_rd(2'b00, 7'h10, 16'h0000, 16'h1234, 0);
    chk("t3_st", 32'(st_cnt), 32'd1);
    chk("t3_ld", 32'(ld_cnt), 32'd2);
    chk("t3_we_cycles", 32'(we_cycles), 32'd2);

    // 4: backpressure for 5 cycles
    do_rd(2'b00, 7'h05, 16'h0000, 16'hA5A5, 5);
    chk("t4_ld", 32'(ld_cnt), 32'd3);

    // 5: reserved op
    issue(2'b11, 7'h22, 16'hDEAD);
    chk("rsvd_err", 32'(op_err), 32'd1);
    chk("rsvd_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rsvd_err_drop", 32'(op_err), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rsvd_we_cycles", 32'(we_cycles), 32'd2);
    chk("rsvd_st", 32'(st_cnt), 32'd1);
    chk("rsvd_ld", 32'(ld_cnt), 32'd3);

    // 6: reset during WAIT of a LOAD drops it
    issue(2'b00, 7'h10, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_we", 32'(mem_we), 32'd0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 chk("dropped_no_resp", 32'(resp_valid), 32'd0);
    end
    do_rd(2'b00, 7'h10, 16'h0000, 16'h1234, 0);
    chk("t6_ld", 32'(ld_cnt), 32'd1);
    chk("t6_st", 32'(st_cnt), 32'd0);

    // 6b: 2-bit store counter saturates
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      r2_addr = 7'(i); r2_wdata = 16'(i); r2_op = 2'b01; r2_valid = 1'b1;
      @(posedge clk); #1 r2_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("sat_st", 32'(r2_st_cnt), (i > 3) ? 32'd3 : 32'(i));
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
